// File: rtl/mul_pkg.sv
// Shared types for the shift-and-add multiplier.
// Holds the controller state encoding and product-width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } mul_state_t;

  function automatic int pw(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mul_abs_neg.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and the final sign fix.
module mul_abs_neg #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mul_seq_shift_add.sv
// Radix-2 shift-and-add sequential multiplier.
// Sign handled on magnitudes; exits once multiplier bits run out.
module mul_seq_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SIGNED_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = pw(WIDTH);

  mul_state_t       state;
  mul_state_t       state_nxt;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mreg;
  logic [PW-1:0]    acc;
  logic             neg;
  logic             done_q;
  logic [PW-1:0]    product_q;

  logic             sgn;
  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    res;

  assign sgn    = signed_mode & (SIGNED_EN != 0);
  assign accept = (state == IDLE) & start;

  // -2^(W-1) negates to itself, read as unsigned 2^(W-1)
  mul_abs_neg #(.W(WIDTH)) u_abs_a (
    .x   (a_in),
    .neg (sgn & a_in[WIDTH-1]),
    .y   (a_mag)
  );

  mul_abs_neg #(.W(WIDTH)) u_abs_b (
    .x   (b_in),
    .neg (sgn & b_in[WIDTH-1]),
    .y   (b_mag)
  );

  mul_abs_neg #(.W(PW)) u_fix (
    .x   (acc),
    .neg (neg),
    .y   (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (mreg == '0) state_nxt = SIGN;
      SIGN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mreg      <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        mcand <= {{WIDTH{1'b0}}, a_mag};
        mreg  <= b_mag;
        acc   <= '0;
        neg   <= sgn & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
      end else if (state == CALC && mreg != '0) begin
        if (mreg[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        mreg  <= mreg >> 1;
      end else if (state == SIGN) begin
        product_q <= res;
        done_q    <= 1'b1;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul_seq_shift_add.sv
// Scoreboard bench for the shift-and-add multiplier.
// Arithmetic reference model; decoupled driver and monitor.
module tb_mul_seq_shift_add;

  localparam int W  = 16;
  localparam int PW = 32;

  typedef struct {
    logic [PW-1:0] p;
    int            dc;
    int            n;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          signed_mode = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  logic          start0 = 1'b0;
  logic          signed_mode0 = 1'b0;
  logic [W-1:0]  a_in0 = '0;
  logic [W-1:0]  b_in0 = '0;
  logic          busy0;
  logic          done0;
  logic [PW-1:0] product0;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_seq_shift_add #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signed_mode(signed_mode), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product)
  );

  mul_seq_shift_add #(.WIDTH(W), .SIGNED_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .signed_mode(signed_mode0), .a_in(a_in0), .b_in(b_in0),
    .busy(busy0), .done(done0), .product(product0)
  );

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input bit s, input int c);
    exp_t   e;
    longint av, bv, bm;
    int     n;
    av = s ? longint'($signed(a)) : longint'(a);
    bv = s ? longint'($signed(b)) : longint'(b);
    e.p = PW'(av * bv);
    bm = (bv < 0) ? -bv : bv;
    n = 0;
    while (bm > 0) begin
      n++;
      bm = bm / 2;
    end
    e.n  = n;
    e.dc = c + 3 + n;
    return e;
  endfunction

  task automatic check(input string nm, input logic [PW-1:0] act,
                       input logic [PW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // monitor: pops on every done pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt <= 0;
    end else begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", product, e.p);
          check("done_cycle", PW'(cyc), PW'(e.dc));
          check("busy_cycles", PW'(busy_cnt), PW'(e.n + 2));
          check("busy_in_done", PW'(busy), '0);
        end
        busy_cnt <= 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit s);
    a_in = a;
    b_in = b;
    signed_mode = s;
    start = 1'b1;
    sb.push_back(model(a, b, s, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 60 && !done; i++) @(negedge clk);
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout_done: got done=0 expected 1");
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           sel;

    #12;
    check("rst_busy", PW'(busy), '0);
    check("rst_done", PW'(done), '0);
    check("rst_product", product, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'd17, 16'd5, 1'b0);
    drain();
    issue(16'hFFFD, 16'd7, 1'b1);
    drain();
    issue(16'hFFFD, 16'd7, 1'b0);
    drain();
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    drain();
    issue(16'h8000, 16'h8000, 1'b1);
    drain();
    issue(16'd1234, 16'd0, 1'b1);
    drain();
    issue(16'd0, 16'hFFFF, 1'b1);
    drain();

    // start while busy must be ignored
    issue(16'd100, 16'd300, 1'b0);
    @(negedge clk);
    a_in = 16'd9;
    b_in = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // back-to-back: start in the done cycle
    issue(16'd45, 16'd3, 1'b0);
    wait_done();
    issue(16'hFF00, 16'h0102, 1'b1);
    drain();

    // async reset mid-CALC
    issue(16'd77, 16'hFFFF, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", PW'(busy), '0);
    check("abort_done", PW'(done), '0);
    check("abort_product", product, '0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    issue(16'd300, 16'd200, 1'b0);
    drain();

    // unsigned-only build ignores signed_mode
    a_in0 = 16'hFFFD;
    b_in0 = 16'd7;
    signed_mode0 = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 40 && !done0; i++) @(negedge clk);
    check("unsigned_build_done", PW'(done0), 32'd1);
    check("unsigned_build", product0, 32'h0006FFEB);
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 7);
      ra = W'($urandom);
      rb = W'($urandom);
      if (sel == 0) rb = '0;
      if (sel == 1) ra = 16'h8000;
      if (sel == 2) rb = W'($urandom_range(0, 15));
      issue(ra, rb, 1'($urandom_range(0, 1)));
      if (k % 3 == 0) begin
        wait_done();
        issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
